// File: rtl/traceback_unit_pkg.sv
// Shared encodings for the traceback datapath: move codes, symbol word layout and FSM states.
// The score/symbol generator imports the same definitions so both sides agree on the bit layout.
package traceback_unit_pkg;

    localparam int unsigned SYM_W        = 3;
    localparam int unsigned SYM_DIAG_BIT = 2;
    localparam int unsigned SYM_UP_BIT   = 1;
    localparam int unsigned SYM_LEFT_BIT = 0;

    typedef enum logic [1:0] {
        MOVE_DIAG = 2'b00,
        MOVE_UP   = 2'b01,
        MOVE_LEFT = 2'b10
    } move_e;

    typedef struct packed {
        logic diag;
        logic up;
        logic left;
    } sym_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_READ = 3'd1,
        ST_WAIT = 3'd2,
        ST_EMIT = 3'd3,
        ST_FIN  = 3'd4,
        ST_ERR  = 3'd5
    } state_e;

endpackage

// File: rtl/tb_addr_gen.sv
// Row-major cell address i*(N+1)+j built from shifted copies of i, one per set bit of N+1,
// so no multiplier is needed whether or not N+1 is a power of two.
module tb_addr_gen #(
    parameter int unsigned N       = 128,
    parameter int unsigned BitAddr = $clog2(N + 1),
    parameter int unsigned AddrW   = $clog2((N + 1) * (N + 1) - 1)
) (
    input  logic [BitAddr:0]  i,
    input  logic [BitAddr:0]  j,
    output logic [AddrW-1:0]  addr
);

    localparam int unsigned NP1 = N + 1;

    logic [AddrW-1:0] acc;

    always_comb begin
        acc = '0;
        for (int unsigned k = 0; k < 32; k++) begin
            if (((NP1 >> k) & 32'd1) == 32'd1) begin
                acc = acc + (AddrW'(i) << k);
            end
        end
        addr = acc + AddrW'(j);
    end

endmodule

// File: rtl/traceback_unit.sv
// Walks the direction matrix from (N,N) back to (0,0), reading one symbol per interior cell
// and streaming the chosen moves out over a valid/ready handshake.
module traceback_unit
    import traceback_unit_pkg::*;
#(
    parameter int unsigned N       = 128,
    parameter int unsigned BitAddr = $clog2(N + 1),
    parameter int unsigned AddrW   = $clog2((N + 1) * (N + 1) - 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               sym_rd_en,
    output logic [AddrW-1:0]   sym_addr,
    input  logic [SYM_W-1:0]   sym_data,
    output logic               move_valid,
    input  logic               move_ready,
    output logic [1:0]         move,
    output logic [BitAddr:0]   move_i,
    output logic [BitAddr:0]   move_j,
    output logic               busy,
    output logic               done,
    output logic               error
);

    localparam int unsigned IdxW = BitAddr + 1;

    state_e           state_q;
    state_e           state_d;
    logic [BitAddr:0] i_q;
    logic [BitAddr:0] i_d;
    logic [BitAddr:0] j_q;
    logic [BitAddr:0] j_d;
    move_e            move_q;
    move_e            move_d;
    logic             error_d;
    logic             rd_en_d;
    logic [AddrW-1:0] addr_d;
    sym_t             sym;

    assign sym    = sym_t'(sym_data);
    assign move   = 2'(move_q);
    assign move_i = i_q;
    assign move_j = j_q;

    // Address is formed from the next-cycle cell so the read strobe and address register together.
    tb_addr_gen #(
        .N       (N),
        .BitAddr (BitAddr),
        .AddrW   (AddrW)
    ) u_addr_gen (
        .i    (i_d),
        .j    (j_d),
        .addr (addr_d)
    );

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        move_d  = move_q;
        error_d = error;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_READ;
                    i_d     = IdxW'(N);
                    j_d     = IdxW'(N);
                    error_d = 1'b0;
                end
            end
            ST_READ: begin
                if (i_q == '0 && j_q == '0) begin
                    state_d = ST_FIN;
                end else if (i_q == '0) begin
                    move_d  = MOVE_LEFT;
                    state_d = ST_EMIT;
                end else if (j_q == '0) begin
                    move_d  = MOVE_UP;
                    state_d = ST_EMIT;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                state_d = ST_EMIT;
                if (sym.diag) begin
                    move_d = MOVE_DIAG;
                end else if (sym.up) begin
                    move_d = MOVE_UP;
                end else if (sym.left) begin
                    move_d = MOVE_LEFT;
                end else begin
                    state_d = ST_ERR;
                    error_d = 1'b1;
                end
            end
            ST_EMIT: begin
                if (move_ready) begin
                    state_d = ST_READ;
                    case (move_q)
                        MOVE_DIAG: begin
                            i_d = i_q - IdxW'(1);
                            j_d = j_q - IdxW'(1);
                        end
                        MOVE_UP:   i_d = i_q - IdxW'(1);
                        MOVE_LEFT: j_d = j_q - IdxW'(1);
                        default: ;
                    endcase
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign rd_en_d = (state_d == ST_READ) && (i_d != '0) && (j_d != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            i_q        <= '0;
            j_q        <= '0;
            move_q     <= MOVE_DIAG;
            error      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            move_valid <= 1'b0;
            sym_rd_en  <= 1'b0;
            sym_addr   <= '0;
        end else begin
            state_q    <= state_d;
            i_q        <= i_d;
            j_q        <= j_d;
            move_q     <= move_d;
            error      <= error_d;
            busy       <= (state_d != ST_IDLE);
            done       <= (state_d == ST_FIN);
            move_valid <= (state_d == ST_EMIT);
            sym_rd_en  <= rd_en_d;
            sym_addr   <= addr_d;
        end
    end

endmodule

// File: tb/tb_traceback_unit.sv
// Randomised bench for traceback_unit (N=4): a plain path-walking model predicts moves,
// reads and completion status; one negedge process compares every handshake against it.
module tb_traceback_unit;
    import traceback_unit_pkg::*;

    localparam int N       = 4;
    localparam int NP1     = N + 1;
    localparam int BitAddr = 3;
    localparam int AddrW   = 5;

    logic               clk = 1'b0;
    logic               rst;
    logic               start = 1'b0;
    logic               sym_rd_en;
    logic [AddrW-1:0]   sym_addr;
    logic [2:0]         sym_data = 3'b000;
    logic               move_valid;
    logic               move_ready = 1'b0;
    logic [1:0]         move;
    logic [BitAddr:0]   move_i;
    logic [BitAddr:0]   move_j;
    logic               busy;
    logic               done;
    logic               error;

    logic [2:0]         sym_mem [0:31];
    logic [9:0]         exp_q [$];
    logic [AddrW-1:0]   exp_addr_q [$];

    int n_checks = 0;
    int n_fail   = 0;
    int moves_seen, reads_seen, done_seen, diag_seen, hold_seen;
    int rmode = 0;
    int stall_cnt = 0;
    bit prev_stall = 1'b0;
    logic [9:0] prev_bus = '0;

    traceback_unit #(.N(N), .BitAddr(BitAddr), .AddrW(AddrW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .sym_rd_en  (sym_rd_en),
        .sym_addr   (sym_addr),
        .sym_data   (sym_data),
        .move_valid (move_valid),
        .move_ready (move_ready),
        .move       (move),
        .move_i     (move_i),
        .move_j     (move_j),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    // Symbol RAM with one cycle of read latency.
    always @(posedge clk) begin
        if (sym_rd_en) sym_data <= sym_mem[sym_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [9:0] mk(input logic [1:0] m, input int i, input int j);
        return {m, 4'(i), 4'(j)};
    endfunction

    task automatic fill(input logic [2:0] v);
        for (int a = 0; a < 32; a++) sym_mem[a] = v;
    endtask

    // Reference walk: border cells need no read, interior cells pick diag > up > left.
    task automatic model(output bit e_err);
        int i;
        int j;
        int a;
        logic [2:0] s;
        i = N;
        j = N;
        e_err = 1'b0;
        exp_q.delete();
        exp_addr_q.delete();
        while (i > 0 || j > 0) begin
            if (i == 0) begin
                exp_q.push_back(mk(2'b10, i, j));
                j--;
            end else if (j == 0) begin
                exp_q.push_back(mk(2'b01, i, j));
                i--;
            end else begin
                a = i * NP1 + j;
                exp_addr_q.push_back(AddrW'(a));
                s = sym_mem[a];
                if (s[SYM_DIAG_BIT]) begin
                    exp_q.push_back(mk(2'b00, i, j));
                    i--;
                    j--;
                end else if (s[SYM_UP_BIT]) begin
                    exp_q.push_back(mk(2'b01, i, j));
                    i--;
                end else if (s[SYM_LEFT_BIT]) begin
                    exp_q.push_back(mk(2'b10, i, j));
                    j--;
                end else begin
                    e_err = 1'b1;
                    break;
                end
            end
        end
    endtask

    // Ready driver: 0 = tied high, 1 = random, 2 = hold low for 5 cycles on the first move.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                0: move_ready = 1'b1;
                1: move_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (move_valid && stall_cnt < 5) begin
                        move_ready = 1'b0;
                        stall_cnt++;
                    end else begin
                        move_ready = 1'b1;
                    end
                end
            endcase
        end
    end

    // Compare process: every transfer, every read strobe, and hold-stability while stalled.
    initial begin
        logic [9:0] e;
        logic [AddrW-1:0] ea;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("hold_valid", 32'(move_valid), 32'd1);
                    check("hold_bus", 32'({move, move_i, move_j}), 32'(prev_bus));
                end
                if (move_valid) begin
                    if (move_ready) begin
                        if (exp_q.size() == 0) begin
                            check("unexpected_move", 32'({move, move_i, move_j}), 32'h3ff);
                        end else begin
                            e = exp_q.pop_front();
                            check("move", 32'({move, move_i, move_j}), 32'(e));
                        end
                        moves_seen++;
                        if (move == 2'b00) diag_seen++;
                    end else begin
                        hold_seen++;
                    end
                    prev_stall = !move_ready;
                    prev_bus   = {move, move_i, move_j};
                end else begin
                    prev_stall = 1'b0;
                end
                if (sym_rd_en) begin
                    reads_seen++;
                    if (exp_addr_q.size() == 0) begin
                        check("unexpected_read", 32'(sym_addr), 32'hffff);
                    end else begin
                        ea = exp_addr_q.pop_front();
                        check("sym_addr", 32'(sym_addr), 32'(ea));
                    end
                end
                if (done) done_seen++;
            end
        end
    end

    task automatic run_once(input int mode, input bit spam);
        bit e_err;
        bit fin;
        int nm;
        int nr;
        model(e_err);
        nm = exp_q.size();
        nr = exp_addr_q.size();
        moves_seen = 0;
        reads_seen = 0;
        done_seen  = 0;
        diag_seen  = 0;
        hold_seen  = 0;
        stall_cnt  = 0;
        rmode      = mode;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("start_busy", 32'(busy), 32'd1);
        check("start_error_clear", 32'(error), 32'd0);
        fin = 1'b0;
        for (int c = 0; c < 400 && !fin; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (!busy) fin = 1'b1;
            else if (spam && $urandom_range(0, 2) == 0) start = 1'b1;
        end
        start = 1'b0;
        check("timeout", 32'(fin), 32'd1);
        check("moves_left", 32'(exp_q.size()), 32'd0);
        check("reads_left", 32'(exp_addr_q.size()), 32'd0);
        check("move_count", 32'(moves_seen), 32'(nm));
        check("read_count", 32'(reads_seen), 32'(nr));
        check("done_count", 32'(done_seen), e_err ? 32'd0 : 32'd1);
        check("error_flag", 32'(error), 32'(e_err));
        if (!e_err) check("moves_plus_diag", 32'(moves_seen + diag_seen), 32'(2 * N));
        rmode = 0;
    endtask

    initial begin
        bit e_err;
        bit found;
        rst = 1'b0;
        fill(3'b000);
        #2 rst = 1'b1;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(move_valid), 32'd0);
        check("rst_rd_en", 32'(sym_rd_en), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_move_ij", 32'({move, move_i, move_j}), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // All diagonal.
        fill(3'b100);
        model(e_err);
        check("pin_diag_n", 32'(exp_q.size()), 32'd4);
        for (int k = 0; k < 4; k++) check("pin_diag_mv", 32'(exp_q[k]), 32'(mk(2'b00, 4 - k, 4 - k)));
        run_once(0, 1'b0);
        check("diag_reads", 32'(reads_seen), 32'd4);
        check("diag_done", 32'(done_seen), 32'd1);

        // All up: up the right column, then left along the top row.
        fill(3'b010);
        model(e_err);
        check("pin_up_n", 32'(exp_q.size()), 32'd8);
        check("pin_up_last", 32'(exp_q[3]), 32'(mk(2'b01, 1, 4)));
        check("pin_left_first", 32'(exp_q[4]), 32'(mk(2'b10, 0, 4)));
        check("pin_left_last", 32'(exp_q[7]), 32'(mk(2'b10, 0, 1)));
        run_once(0, 1'b0);
        check("up_moves", 32'(moves_seen), 32'd8);
        check("up_reads", 32'(reads_seen), 32'd4);

        // Priority: 111 -> diag, 011 -> up.
        fill(3'b100);
        sym_mem[4 * NP1 + 4] = 3'b111;
        sym_mem[3 * NP1 + 3] = 3'b011;
        model(e_err);
        check("pin_prio_0", 32'(exp_q[0]), 32'(mk(2'b00, 4, 4)));
        check("pin_prio_1", 32'(exp_q[1]), 32'(mk(2'b01, 3, 3)));
        run_once(0, 1'b0);

        // Backpressure: ready low for 5 cycles on the first move.
        fill(3'b100);
        run_once(2, 1'b0);
        check("stall_hold_cycles", 32'(hold_seen), 32'd5);

        // Empty symbol after one diagonal step.
        fill(3'b100);
        sym_mem[3 * NP1 + 3] = 3'b000;
        model(e_err);
        check("pin_err_flag", 32'(e_err), 32'd1);
        check("pin_err_moves", 32'(exp_q.size()), 32'd1);
        run_once(0, 1'b0);
        check("err_busy_drop", 32'(busy), 32'd0);
        fill(3'b100);
        run_once(0, 1'b0);

        // Reset while waiting on the symbol RAM abandons the traceback.
        fill(3'b100);
        model(e_err);
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 50 && !found; c++) begin
            @(negedge clk);
            if (sym_rd_en) found = 1'b1;
        end
        check("reach_read", 32'(found), 32'd1);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("midrst_outputs", 32'({busy, move_valid, sym_rd_en, done, error}), 32'd0);
        check("midrst_move_ij", 32'({move, move_i, move_j}), 32'd0);
        exp_q.delete();
        exp_addr_q.delete();
        done_seen = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (20) @(negedge clk);
        check("midrst_no_done", 32'(done_seen), 32'd0);
        check("midrst_idle", 32'(busy), 32'd0);

        // Random matrices, random ready, start pulses while busy.
        for (int t = 0; t < 10; t++) begin
            for (int a = 0; a < 32; a++)
                sym_mem[a] = ($urandom_range(0, 19) == 0) ? 3'b000 : 3'($urandom_range(1, 7));
            run_once(1, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
